// File: rtl/edge_window_scheduler_if.sv
// Pixel-stream, window/filter and result handshake bundle for edge_window_scheduler.
interface edge_window_scheduler_if;
  logic         start;
  logic         in_valid;
  logic [7:0]   in_pixel;
  logic         in_ready;
  logic [199:0] win_out;
  logic [7:0]   filt_pixel;
  logic         out_valid;
  logic [7:0]   out_pixel;
  logic         out_ready;
  logic         busy;
  logic         frame_done;

  modport slave (
    input  start, in_valid, in_pixel, filt_pixel, out_ready,
    output in_ready, win_out, out_valid, out_pixel, busy, frame_done
  );
  modport master (
    output start, in_valid, in_pixel, filt_pixel, out_ready,
    input  in_ready, win_out, out_valid, out_pixel, busy, frame_done
  );
endinterface

// File: rtl/edge_window_scheduler.sv
// Raster 5x5 window scheduler feeding an external combinational edge filter.
// Optional EDGE_FRAME_CNT_EN adds a 16-bit frame_count output.
module edge_window_scheduler #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  edge_window_scheduler_if.slave  bus
`ifdef EDGE_FRAME_CNT_EN
  ,
  output logic [15:0]             frame_count
`endif
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]           state;
  logic [XW-1:0]        x;
  logic [YW-1:0]        y;
  logic [31:0]          lb [IMG_W];
  logic [4:0][4:0][7:0] win;
  logic                 win_vld;
  logic                 out_valid;
  logic [7:0]           out_pixel;
  logic                 stall, accept, row_end, last_px, flush_done;
  logic [31:0]          col;

  // Column word per x: [31:24] is row y-4 (oldest), [7:0] is row y-1.
  assign col        = lb[x];
  assign stall      = out_valid && !bus.out_ready;
  assign bus.in_ready = (state == RUN) && !stall;
  assign accept     = bus.in_valid && bus.in_ready;
  assign row_end    = (x == XW'(IMG_W - 1));
  assign last_px    = row_end && (y == YW'(IMG_H - 1));
  assign flush_done = (state == FLUSH) && !win_vld && !out_valid;

  assign bus.win_out    = win;
  assign bus.out_valid  = out_valid;
  assign bus.out_pixel  = out_pixel;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = flush_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state <= RUN;
          x     <= '0;
          y     <= '0;
        end
        RUN: if (accept) begin
          if (row_end) begin
            x <= '0;
            y <= last_px ? '0 : y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
          if (last_px) state <= FLUSH;
        end
        FLUSH: if (flush_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) lb[x] <= {col[23:0], bus.in_pixel};
  end

  // Window and win_vld freeze while the result register is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win     <= '0;
      win_vld <= 1'b0;
    end else if (accept) begin
      for (int r = 0; r < 5; r++) win[r][3:0] <= win[r][4:1];
      win[0][4] <= col[31:24];
      win[1][4] <= col[23:16];
      win[2][4] <= col[15:8];
      win[3][4] <= col[7:0];
      win[4][4] <= bus.in_pixel;
      win_vld   <= (x >= XW'(4)) && (y >= YW'(4));
    end else if (!stall) begin
      win_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
    end else if (win_vld && !stall) begin
      out_valid <= 1'b1;
      out_pixel <= bus.filt_pixel;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef EDGE_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          frame_count <= '0;
    else if (flush_done) frame_count <= frame_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_edge_window_scheduler.sv
// Randomised self-checking bench for edge_window_scheduler on an 8x8 image.
module tb_edge_window_scheduler;
  localparam int W = 8;
  localparam int H = 8;
  localparam int NRES = (W - 4) * (H - 4);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  edge_window_scheduler_if bus();
`ifdef EDGE_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  edge_window_scheduler #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef EDGE_FRAME_CNT_EN
    , .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] img_r [H][W];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int done_cnt, lat, stall_bad, stall_seen, busy_seen;
  bit tmo;

  // Stand-in edge filter: horizontal gradient of rows 0..3 scaled by 8, plus a
  // vertical term that is zero for row-invariant images.
  function automatic logic [7:0] filt_fn(input logic [199:0] w);
    int d, v, t;
    d = 0; v = 0;
    for (int r = 0; r < 4; r++) d += int'(w[r*40+32 +: 8]) - int'(w[r*40 +: 8]);
    for (int r = 1; r < 5; r++)
      for (int c = 0; c < 5; c++) v += int'(w[r*40+c*8 +: 8]) - int'(w[c*8 +: 8]);
    t = 8 * d + v;
    return t[7:0];
  endfunction

  assign bus.filt_pixel = filt_fn(bus.win_out);

  function automatic logic [7:0] pix(input int pat, input int px, input int py);
    case (pat)
      0:       return 8'd10;
      1:       return px[7:0];
      default: return img_r[py][px];
    endcase
  endfunction

  // Reference: every full 5x5 neighbourhood of the image, raster order.
  task automatic build_exp(input int pat);
    logic [199:0] w;
    exp_q.delete();
    for (int yy = 4; yy < H; yy++)
      for (int xx = 4; xx < W; xx++) begin
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++) w[r*40+c*8 +: 8] = pix(pat, xx - 4 + c, yy - 4 + r);
        exp_q.push_back(filt_fn(w));
      end
  endtask

  task automatic randomize_img();
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) img_r[yy][xx] = 8'($urandom);
  endtask

  task automatic run_frame(input int pat, input int st_at, input int st_len, input bit rnd,
                           input int start_at, input int abort_at);
    int px, cyc, acc_cyc, first_ov, st_rem;
    bit st_on, st_done, aborted;
    logic [7:0] st_pix;
    px = 0; cyc = 0; acc_cyc = -100; first_ov = -1; st_rem = 0;
    st_on = 0; st_done = 0; aborted = 0; st_pix = '0;
    got_q.delete(); done_cnt = 0; stall_bad = 0; stall_seen = 0; busy_seen = 0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    while (cyc < 3000) begin
      if (abort_at > 0 && px == abort_at) begin
        aborted = 1;
        break;
      end
      if (!st_done && !st_on && st_len > 0 && px >= st_at && bus.out_valid) begin
        st_on = 1; st_rem = st_len; st_pix = bus.out_pixel;
      end
      bus.in_valid  = (px < W * H) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      bus.in_pixel  = pix(pat, px % W, px / W);
      bus.out_ready = st_on ? 1'b0 : (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      bus.start     = (cyc == start_at);
      #1;
      if (st_on) begin
        stall_seen++;
        if (!bus.out_valid || bus.out_pixel !== st_pix || bus.in_ready) stall_bad++;
        st_rem--;
        if (st_rem == 0) begin st_on = 0; st_done = 1; end
      end
      if (bus.busy) busy_seen = 1;
      if (bus.in_valid && bus.in_ready) begin
        if (px == 4 * W + 4) acc_cyc = cyc;
        px++;
      end
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_pixel);
      if (bus.out_valid && first_ov < 0) first_ov = cyc;
      if (bus.frame_done) done_cnt++;
      if (done_cnt > 0) break;
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b1;
    tmo = (done_cnt == 0) && !aborted;
    lat = first_ov - acc_cyc;
  endtask

  task automatic check_frame(input string tag, input int pat);
    build_exp(pat);
    checks++;
    if (tmo) begin errors++; $display("FAIL %s_timeout got=no_frame_done exp=frame_done", tag); end
    checks++;
    if (got_q.size() !== NRES) begin
      errors++; $display("FAIL %s_count got=%0d exp=%0d", tag, got_q.size(), NRES);
    end
    for (int i = 0; i < NRES && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL %s_pix[%0d] got=%0d exp=%0d", tag, i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL %s_done got=%0d exp=1", tag, done_cnt); end
  endtask

  task automatic test_reset();
    bus.start = 0; bus.in_valid = 0; bus.in_pixel = 0; bus.out_ready = 1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_pixel !== 8'd0) begin errors++; $display("FAIL rst_out_pixel got=%0d exp=0", bus.out_pixel); end
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got=%b exp=0", bus.frame_done); end
    checks++; if (bus.win_out !== '0)     begin errors++; $display("FAIL rst_win_out got=%h exp=0", bus.win_out); end
  endtask

  task automatic test_constant();
    run_frame(0, 0, 0, 1'b0, -1, 0);
    check_frame("const", 0);
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== 8'd0) begin errors++; $display("FAIL const_zero[%0d] got=%0d exp=0", i, got_q[i]); end
    end
  endtask

  task automatic test_ramp();
    run_frame(1, 0, 0, 1'b0, -1, 0);
    check_frame("ramp", 1);
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== 8'd128) begin errors++; $display("FAIL ramp_128[%0d] got=%0d exp=128", i, got_q[i]); end
    end
    checks++; if (lat !== 2) begin errors++; $display("FAIL ramp_latency got=%0d exp=2", lat); end
    checks++; if (busy_seen !== 1) begin errors++; $display("FAIL ramp_busy got=%0d exp=1", busy_seen); end
    @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ramp_idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_backpressure();
    run_frame(1, 45, 5, 1'b0, -1, 0);
    check_frame("bp", 1);
    checks++; if (stall_seen !== 5) begin errors++; $display("FAIL bp_stall_len got=%0d exp=5", stall_seen); end
    checks++; if (stall_bad !== 0)  begin errors++; $display("FAIL bp_stall_hold got=%0d bad exp=0", stall_bad); end
  endtask

  task automatic test_reset_abort();
    run_frame(1, 0, 0, 1'b0, -1, 30);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 0 || bus.out_valid !== 0 || bus.out_pixel !== 0 || bus.busy !== 0 ||
        bus.frame_done !== 0 || bus.win_out !== '0) begin
      errors++;
      $display("FAIL abort_reset got=ir%b ov%b op%0d b%b fd%b exp=all_zero",
               bus.in_ready, bus.out_valid, bus.out_pixel, bus.busy, bus.frame_done);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_no_restart got=%b exp=0", bus.busy); end
    run_frame(0, 0, 0, 1'b0, -1, 0);
    check_frame("abort_const", 0);
  endtask

  task automatic test_start_in_run();
    randomize_img();
    run_frame(2, 0, 0, 1'b0, 20, 0);
    check_frame("start_run", 2);
  endtask

  task automatic test_random_bp();
    for (int f = 0; f < 2; f++) begin
      randomize_img();
      run_frame(2, 0, 0, 1'b1, -1, 0);
      check_frame("rand", 2);
    end
  endtask

`ifdef EDGE_FRAME_CNT_EN
  task automatic test_frame_count();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL fcnt0 got=%0d exp=0", frame_count); end
    for (int f = 1; f <= 2; f++) begin
      run_frame(0, 0, 0, 1'b0, -1, 0);
      @(negedge clk); #1;
      checks++;
      if (frame_count !== 16'(f)) begin errors++; $display("FAIL fcnt%0d got=%0d exp=%0d", f, frame_count, f); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_backpressure();
    test_reset_abort();
    test_start_in_run();
    test_random_bp();
`ifdef EDGE_FRAME_CNT_EN
    test_frame_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
